mcdt_rr_arbiter: RTL

//  Output arbiter of the MCDT: decides which of the three channel slave FIFOs
//  is drained onto the shared MCDT output bus. Supports round-robin or

---
 rtl/mcdt_rr_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mcdt_rr_arbiter.sv
// MCDT output arbiter: drains one of three show-ahead channel FIFOs per cycle
// onto the shared output bus, round-robin or fixed priority, with bursts.
module mcdt_rr_arbiter #(
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [2:0]    cfg_en_i,
  input  logic          cfg_mode_i,
  input  logic [1:0]    cfg_burst_i,
  input  logic [2:0]    ch_req_i,
  input  logic [DW-1:0] ch0_data_i,
  input  logic [DW-1:0] ch1_data_i,
  input  logic [DW-1:0] ch2_data_i,
  output logic [2:0]    ch_pop_o,
  output logic [DW-1:0] mcdt_data_o,
  output logic          mcdt_val_o,
  output logic [1:0]    mcdt_id_o
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic [1:0]         owner_r;
  logic [1:0]         burst_len_r;
  logic [CNT_W-1:0]   burst_cnt_r;
  logic [1:0]         rr_ptr_r;

  logic [2:0]         elig_s;
  logic               keep_s;
  logic               release_s;
  logic               start_s;
  logic               pop_any_s;
  logic [1:0]         arb_ptr_s;
  logic [1:0]         win_s;
  logic [1:0]         pop_idx_s;
  logic [DW-1:0]      pop_data_s;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    case (p)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] pick_fp(input logic [2:0] el);
    if (el[0])      return 2'd0;
    else if (el[1]) return 2'd1;
    else if (el[2]) return 2'd2;
    else            return 2'd0;
  endfunction

  function automatic logic [1:0] pick_rr(input logic [2:0] el, input logic [1:0] ptr);
    logic [1:0] c0, c1, c2;
    c0 = (ptr == 2'd3) ? 2'd0 : ptr;
    c1 = inc3(c0);
    c2 = inc3(c1);
    if (el[c0])      return c0;
    else if (el[c1]) return c1;
    else if (el[c2]) return c2;
    else             return 2'd0;
  endfunction

  assign elig_s = ch_req_i & cfg_en_i;

  // State register and grant bookkeeping
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= IDLE;
      owner_r     <= 2'd0;
      burst_len_r <= 2'd0;
      burst_cnt_r <= '0;
      rr_ptr_r    <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= arb_ptr_s;
      if (start_s) begin
        owner_r     <= win_s;
        burst_len_r <= cfg_burst_i;
        burst_cnt_r <= CNT_W'(1);
      end else if (keep_s) begin
        burst_cnt_r <= burst_cnt_r + CNT_W'(1);
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
    end
  end

  // Next-state: continue the burst, or release and re-arbitrate with no bubble
  always_comb begin
    keep_s      = 1'b0;
    release_s   = 1'b0;
    arb_ptr_s   = rr_ptr_r;
    win_s       = 2'd0;
    start_s     = 1'b0;
    state_nxt_s = IDLE;
    if (state_r == GRANT) begin
      keep_s    = elig_s[owner_r] && (burst_cnt_r <= CNT_W'(burst_len_r));
      release_s = ~keep_s;
    end else begin
      keep_s    = 1'b0;
      release_s = 1'b0;
    end
    if (release_s && !cfg_mode_i) begin
      arb_ptr_s = inc3(owner_r);
    end else begin
      arb_ptr_s = rr_ptr_r;
    end
    if (cfg_mode_i) begin
      win_s = pick_fp(elig_s);
    end else begin
      win_s = pick_rr(elig_s, arb_ptr_s);
    end
    start_s = ~keep_s && (elig_s != 3'b000);
    if (keep_s || start_s) begin
      state_nxt_s = GRANT;
    end else begin
      state_nxt_s = IDLE;
    end
  end

  // Pop outputs; suppressed while reset is held so no FIFO is drained
  always_comb begin
    pop_any_s = keep_s | start_s;
    pop_idx_s = keep_s ? owner_r : win_s;
    ch_pop_o  = 3'b000;
    if (rstn_i && pop_any_s) begin
      ch_pop_o[pop_idx_s] = 1'b1;
    end else begin
      ch_pop_o = 3'b000;
    end
    case (pop_idx_s)
      2'd0:    pop_data_s = ch0_data_i;
      2'd1:    pop_data_s = ch1_data_i;
      2'd2:    pop_data_s = ch2_data_i;
      default: pop_data_s = '0;
    endcase
  end

  // Output register: capture the popped word, hold it while idle
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mcdt_data_o <= '0;
      mcdt_val_o  <= 1'b0;
      mcdt_id_o   <= 2'd0;
    end else begin
      mcdt_val_o <= pop_any_s;
      if (pop_any_s) begin
        mcdt_data_o <= pop_data_s;
        mcdt_id_o   <= pop_idx_s;
      end else begin
        mcdt_data_o <= mcdt_data_o;
        mcdt_id_o   <= mcdt_id_o;
      end
    end
  end

endmodule
